// File: rtl/fpq_pkg.sv
// Shared codes and constants for the FPQ egress transmit scheduler.
// Slot types, class codes and block sizing.
package fpq_pkg;

  typedef enum logic [1:0] {
    T_DEF = 2'b00,
    T_MAR = 2'b01,
    T_PCF = 2'b10,
    T_TT  = 2'b11
  } slot_t;

  typedef enum logic [1:0] {
    C_PCF = 2'b00,
    C_TT  = 2'b01,
    C_BE  = 2'b10,
    C_RC  = 2'b11
  } class_t;

  localparam int MTU_VAL   = 95;
  localparam int BLK_BYTES = 16;

endpackage

// File: rtl/fpq_tx_scheduler_if.sv
// Request/length/grant bundle between queue servers and the scheduler.
// Queue servers drive requests; the scheduler drives grants.
interface fpq_tx_scheduler_if #(
  parameter int N_RC  = 2,
  parameter int LEN_W = 8
);

  logic                    req_pcf;
  logic                    req_tt;
  logic                    req_be;
  logic [LEN_W-1:0]        len_pcf;
  logic [LEN_W-1:0]        len_tt;
  logic [LEN_W-1:0]        len_be;
  logic [N_RC-1:0]         req_rc;
  logic [N_RC*LEN_W-1:0]   len_rc;
  logic                    gnt_pcf;
  logic                    gnt_tt;
  logic                    gnt_be;
  logic [N_RC-1:0]         gnt_rc;

  modport master (
    output req_pcf, req_tt, req_be,
    output len_pcf, len_tt, len_be,
    output req_rc, len_rc,
    input  gnt_pcf, gnt_tt, gnt_be, gnt_rc
  );

  modport slave (
    input  req_pcf, req_tt, req_be,
    input  len_pcf, len_tt, len_be,
    input  req_rc, len_rc,
    output gnt_pcf, gnt_tt, gnt_be, gnt_rc
  );

endinterface

// File: rtl/fpq_tx_scheduler_rr_pick.sv
// Combinational round-robin picker over the RC channels.
// Search begins one past ptr and wraps.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] elig,
  input  logic [2:0]   ptr,
  output logic [N-1:0] pick,
  output logic [2:0]   idx,
  output logic         any
);

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && elig[j] && (j > int'(ptr))) begin
        any     = 1'b1;
        pick[j] = 1'b1;
        idx     = 3'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && elig[j] && (j <= int'(ptr))) begin
        any     = 1'b1;
        pick[j] = 1'b1;
        idx     = 3'(j);
      end
    end
  end

endmodule

// File: rtl/fpq_tx_scheduler.sv
// Per-port egress scheduler: picks the class owning the link,
// holds the grant for the frame's blocks, then inserts a one-block gap.
module fpq_tx_scheduler #(
  parameter int N_RC    = 2,
  parameter int LEN_W   = 8,
  parameter int MTU_VAL = fpq_pkg::MTU_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_tick,
  input  logic [1:0]       cur_state,
  input  logic [LEN_W-1:0] cur_value,
  fpq_tx_scheduler_if.slave q,
  output logic [1:0]       tx_class,
  output logic [2:0]       rc_ptr,
  output logic             busy,
  output logic             tx_done,
  output logic             tt_late
);

  import fpq_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TX,
    S_GAP
  } state_t;

  localparam logic [LEN_W-1:0] MTU_L = LEN_W'(MTU_VAL);

  function automatic logic fits(
    input logic [LEN_W-1:0] len,
    input logic [LEN_W-1:0] lim
  );
    return (len != '0) && (len <= lim);
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             gnt_pcf_q, gnt_pcf_d;
  logic             gnt_tt_q, gnt_tt_d;
  logic             gnt_be_q, gnt_be_d;
  logic [N_RC-1:0]  gnt_rc_q, gnt_rc_d;
  class_t           cls_q, cls_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             done_q, done_d;
  logic             late_q, late_d;
  logic             was_tt_q, was_tt_d;

  logic             is_def, is_mar, is_tt, is_pcf;
  logic             e_pcf, e_tt, e_be;
  logic [N_RC-1:0]  e_rc;
  logic [N_RC-1:0]  rc_pick;
  logic [2:0]       rc_idx;
  logic             rc_any;
  logic [LEN_W-1:0] rc_len;

  assign is_def = (cur_state == T_DEF);
  assign is_mar = (cur_state == T_MAR);
  assign is_tt  = (cur_state == T_TT);
  assign is_pcf = (cur_state == T_PCF);

  assign e_pcf = q.req_pcf && is_pcf && fits(q.len_pcf, cur_value);
  assign e_tt  = q.req_tt && is_tt && fits(q.len_tt, cur_value);
  assign e_be  = q.req_be && is_def && fits(q.len_be, MTU_L);

  always_comb begin
    e_rc = '0;
    for (int i = 0; i < N_RC; i++) begin
      e_rc[i] = q.req_rc[i] &&
        ((is_mar && fits(q.len_rc[i*LEN_W +: LEN_W], cur_value)) ||
         (is_def && fits(q.len_rc[i*LEN_W +: LEN_W], MTU_L)));
    end
  end

  rr_pick #(
    .N (N_RC)
  ) u_rr_pick (
    .elig (e_rc),
    .ptr  (ptr_q),
    .pick (rc_pick),
    .idx  (rc_idx),
    .any  (rc_any)
  );

  always_comb begin
    rc_len = '0;
    for (int i = 0; i < N_RC; i++) begin
      if (rc_pick[i]) rc_len = q.len_rc[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gnt_pcf_d = gnt_pcf_q;
    gnt_tt_d  = gnt_tt_q;
    gnt_be_d  = gnt_be_q;
    gnt_rc_d  = gnt_rc_q;
    cls_d     = cls_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    was_tt_d  = is_tt;
    // Only the entry edge into a TT slot can flag a late frame.
    late_d    = is_tt && !was_tt_q && (state_q != S_IDLE) &&
                (cls_q != C_TT);
    unique case (state_q)
      S_IDLE: begin
        if (e_pcf) begin
          gnt_pcf_d = 1'b1;
          rem_d     = q.len_pcf;
          cls_d     = C_PCF;
          state_d   = S_TX;
        end else if (e_tt) begin
          gnt_tt_d = 1'b1;
          rem_d    = q.len_tt;
          cls_d    = C_TT;
          state_d  = S_TX;
        end else if (rc_any) begin
          gnt_rc_d = rc_pick;
          rem_d    = rc_len;
          cls_d    = C_RC;
          ptr_d    = rc_idx;
          state_d  = S_TX;
        end else if (e_be) begin
          gnt_be_d = 1'b1;
          rem_d    = q.len_be;
          cls_d    = C_BE;
          state_d  = S_TX;
        end
      end
      S_TX: begin
        if (blk_tick) begin
          if (rem_q == LEN_W'(1)) begin
            rem_d     = '0;
            gnt_pcf_d = 1'b0;
            gnt_tt_d  = 1'b0;
            gnt_be_d  = 1'b0;
            gnt_rc_d  = '0;
            done_d    = 1'b1;
            state_d   = S_GAP;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      S_GAP: begin
        if (blk_tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      gnt_pcf_q <= 1'b0;
      gnt_tt_q  <= 1'b0;
      gnt_be_q  <= 1'b0;
      gnt_rc_q  <= '0;
      cls_q     <= C_PCF;
      ptr_q     <= '0;
      done_q    <= 1'b0;
      late_q    <= 1'b0;
      was_tt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gnt_pcf_q <= gnt_pcf_d;
      gnt_tt_q  <= gnt_tt_d;
      gnt_be_q  <= gnt_be_d;
      gnt_rc_q  <= gnt_rc_d;
      cls_q     <= cls_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      late_q    <= late_d;
      was_tt_q  <= was_tt_d;
    end
  end

  assign q.gnt_pcf = gnt_pcf_q;
  assign q.gnt_tt  = gnt_tt_q;
  assign q.gnt_be  = gnt_be_q;
  assign q.gnt_rc  = gnt_rc_q;
  assign tx_class  = cls_q;
  assign rc_ptr    = ptr_q;
  assign busy      = (state_q != S_IDLE);
  assign tx_done   = done_q;
  assign tt_late   = late_q;

endmodule

// File: tb/tb_fpq_tx_scheduler.sv
// Directed and randomized bench for fpq_tx_scheduler against a
// transaction-level model of class eligibility, priority and frame timing.
module tb_fpq_tx_scheduler;

  localparam int N_RC  = 2;
  localparam int LEN_W = 8;
  localparam int MTU   = 95;
  localparam int GW    = 3 + N_RC;

  localparam logic [1:0] ST_DEF = 2'b00;
  localparam logic [1:0] ST_MAR = 2'b01;
  localparam logic [1:0] ST_PCF = 2'b10;
  localparam logic [1:0] ST_TT  = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             blk_tick;
  logic [1:0]       cur_state;
  logic [LEN_W-1:0] cur_value;
  logic [1:0]       tx_class;
  logic [2:0]       rc_ptr;
  logic             busy;
  logic             tx_done;
  logic             tt_late;
  logic [GW-1:0]    gv;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  fpq_tx_scheduler_if #(.N_RC(N_RC), .LEN_W(LEN_W)) bus ();

  fpq_tx_scheduler #(
    .N_RC    (N_RC),
    .LEN_W   (LEN_W),
    .MTU_VAL (MTU)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_tick  (blk_tick),
    .cur_state (cur_state),
    .cur_value (cur_value),
    .q         (bus),
    .tx_class  (tx_class),
    .rc_ptr    (rc_ptr),
    .busy      (busy),
    .tx_done   (tx_done),
    .tt_late   (tt_late)
  );

  assign gv = {bus.gnt_pcf, bus.gnt_tt, bus.gnt_be, bus.gnt_rc};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit fits(input int len, input int lim);
    return (len != 0) && (len <= lim);
  endfunction

  function automatic int rc_len(input int ch);
    return int'(bus.len_rc[ch*LEN_W +: LEN_W]);
  endfunction

  function automatic bit rc_ok(input int ch);
    if (!bus.req_rc[ch]) return 0;
    if (cur_state == ST_MAR) return fits(rc_len(ch), int'(cur_value));
    if (cur_state == ST_DEF) return fits(rc_len(ch), MTU);
    return 0;
  endfunction

  // Codes: -1 none, 0 PCF, 1 TT, 2 BE, 10+i RC channel i.
  function automatic int winner();
    int ch;
    if (bus.req_pcf && cur_state == ST_PCF &&
        fits(int'(bus.len_pcf), int'(cur_value))) return 0;
    if (bus.req_tt && cur_state == ST_TT &&
        fits(int'(bus.len_tt), int'(cur_value))) return 1;
    for (int k = 1; k <= N_RC; k++) begin
      ch = (m_ptr + k) % N_RC;
      if (rc_ok(ch)) return 10 + ch;
    end
    if (bus.req_be && cur_state == ST_DEF &&
        fits(int'(bus.len_be), MTU)) return 2;
    return -1;
  endfunction

  function automatic int win_len(input int code);
    case (code)
      0: return int'(bus.len_pcf);
      1: return int'(bus.len_tt);
      2: return int'(bus.len_be);
      default: return rc_len(code - 10);
    endcase
  endfunction

  function automatic logic [GW-1:0] exp_gv(input int code);
    logic [GW-1:0] v;
    v = '0;
    if (code == 0) v[GW-1] = 1'b1;
    else if (code == 1) v[GW-2] = 1'b1;
    else if (code == 2) v[GW-3] = 1'b1;
    else if (code >= 10) v[code-10] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] exp_cls(input int code);
    case (code)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic drop(input int code);
    case (code)
      0: bus.req_pcf = 1'b0;
      1: bus.req_tt = 1'b0;
      2: bus.req_be = 1'b0;
      default: bus.req_rc[code-10] = 1'b0;
    endcase
  endtask

  task automatic clear_reqs();
    bus.req_pcf = 1'b0;
    bus.req_tt  = 1'b0;
    bus.req_be  = 1'b0;
    bus.req_rc  = '0;
  endtask

  task automatic grant_and_run(input string tag, input bit keep,
                               input int sw_at, input logic [1:0] sw_st,
                               input int exp_late);
    int code, len, ticks, guard, late;
    bit t, sw;
    code = winner();
    len  = (code < 0) ? 0 : win_len(code);
    blk_tick = 1'($urandom_range(0, 1));
    step();
    blk_tick = 1'b0;
    chk({tag, " gnt"}, 32'(gv), 32'(exp_gv(code)));
    if (code < 0) begin
      chk({tag, " idle"}, 32'(busy), 32'(0));
      return;
    end
    if (code >= 10) m_ptr = code - 10;
    chk({tag, " class"}, 32'(tx_class), 32'(exp_cls(code)));
    chk({tag, " rc_ptr"}, 32'(rc_ptr), 32'(m_ptr));
    chk({tag, " busy"}, 32'(busy), 32'(1));
    if (!keep) drop(code);
    ticks = 0;
    guard = 0;
    late  = 0;
    sw    = 0;
    while (ticks < len && guard < 4000) begin
      t = 1'($urandom_range(0, 1));
      blk_tick = t;
      step();
      blk_tick = 1'b0;
      guard++;
      if (t) ticks++;
      late += int'(tt_late);
      chk({tag, " hold"}, 32'(gv),
          (ticks < len) ? 32'(exp_gv(code)) : 32'(0));
      chk({tag, " done"}, 32'(tx_done), 32'(t && ticks == len));
      if (!sw && ticks == sw_at) begin
        cur_state = sw_st;
        sw = 1;
      end
    end
    chk({tag, " ticks"}, 32'(ticks), 32'(len));
    t = 0;
    guard = 0;
    while (!t && guard < 50) begin
      t = 1'($urandom_range(0, 1));
      blk_tick = t;
      step();
      blk_tick = 1'b0;
      guard++;
      late += int'(tt_late);
      chk({tag, " gap busy"}, 32'(busy), 32'(!t));
      chk({tag, " gap gnt"}, 32'(gv), 32'(0));
    end
    chk({tag, " gap end"}, 32'(busy), 32'(0));
    chk({tag, " tt_late"}, 32'(late), 32'(exp_late));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " gnt"}, 32'(gv), 32'(0));
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " done"}, 32'(tx_done), 32'(0));
    chk({tag, " late"}, 32'(tt_late), 32'(0));
    chk({tag, " class"}, 32'(tx_class), 32'(0));
    chk({tag, " rc_ptr"}, 32'(rc_ptr), 32'(0));
  endtask

  initial begin
    rst = 1'b1;
    blk_tick = 1'b0;
    cur_state = ST_DEF;
    cur_value = '0;
    clear_reqs();
    bus.len_pcf = '0;
    bus.len_tt  = '0;
    bus.len_be  = '0;
    bus.len_rc  = '0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    step();
    chk_reset("post reset");

    // PCF wins over a pending BE; BE stays ineligible in a PCF slot.
    cur_state = ST_PCF;
    cur_value = 8'd4;
    bus.req_pcf = 1'b1;
    bus.len_pcf = 8'd4;
    bus.req_be  = 1'b1;
    bus.len_be  = 8'd1;
    grant_and_run("pcf", 0, -1, ST_PCF, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pcf be blocked", 32'(gv), 32'(0));
    end
    clear_reqs();

    cur_state = ST_TT;
    cur_value = 8'd3;
    bus.req_tt = 1'b1;
    bus.len_tt = 8'd4;
    grant_and_run("tt too long", 0, -1, ST_TT, 0);
    bus.len_tt = 8'd3;
    grant_and_run("tt fits", 0, -1, ST_TT, 0);
    clear_reqs();

    cur_state = ST_DEF;
    bus.req_rc = 2'b11;
    bus.len_rc = {8'd2, 8'd2};
    grant_and_run("rc a", 1, -1, ST_DEF, 0);
    grant_and_run("rc b", 1, -1, ST_DEF, 0);
    grant_and_run("rc c", 1, -1, ST_DEF, 0);
    clear_reqs();

    // Reset in the middle of an 8-block BE frame.
    bus.req_be = 1'b1;
    bus.len_be = 8'd8;
    step();
    chk("rst frame gnt", 32'(gv), 32'(exp_gv(2)));
    bus.req_be = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blk_tick = 1'b1;
      step();
      blk_tick = 1'b0;
      chk("rst frame hold", 32'(gv), 32'(exp_gv(2)));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 0;
    chk_reset("mid reset");
    step();
    chk_reset("mid reset idle");
    cur_state = ST_PCF;
    cur_value = 8'd2;
    bus.req_pcf = 1'b1;
    bus.len_pcf = 8'd2;
    grant_and_run("after reset", 0, -1, ST_PCF, 0);
    clear_reqs();

    cur_state = ST_MAR;
    cur_value = 8'd5;
    bus.req_rc = 2'b01;
    bus.len_rc = {8'd0, 8'd6};
    bus.req_be = 1'b1;
    bus.len_be = 8'd1;
    grant_and_run("mar wait", 0, -1, ST_MAR, 0);
    cur_state = ST_DEF;
    grant_and_run("mar to def", 0, -1, ST_DEF, 0);
    clear_reqs();

    // Long BE frame overrun by a TT slot start.
    cur_state = ST_DEF;
    cur_value = 8'd10;
    bus.req_be = 1'b1;
    bus.len_be = 8'd20;
    bus.req_tt = 1'b1;
    bus.len_tt = 8'd4;
    grant_and_run("be late", 0, 5, ST_TT, 1);
    grant_and_run("tt after be", 0, -1, ST_TT, 0);
    clear_reqs();

    cur_state = ST_DEF;
    bus.req_be = 1'b1;
    bus.len_be = 8'd96;
    grant_and_run("be over mtu", 0, -1, ST_DEF, 0);
    bus.len_be = 8'd0;
    grant_and_run("be zero", 0, -1, ST_DEF, 0);
    bus.len_be = 8'd95;
    grant_and_run("be mtu", 0, -1, ST_DEF, 0);
    clear_reqs();

    for (int it = 0; it < 40; it++) begin
      cur_state   = 2'($urandom_range(0, 3));
      cur_value   = 8'($urandom_range(0, 10));
      bus.req_pcf = 1'($urandom_range(0, 1));
      bus.req_tt  = 1'($urandom_range(0, 1));
      bus.req_be  = 1'($urandom_range(0, 1));
      bus.req_rc  = 2'($urandom_range(0, 3));
      bus.len_pcf = 8'($urandom_range(0, 10));
      bus.len_tt  = 8'($urandom_range(0, 10));
      bus.len_be  = 8'($urandom_range(0, 10));
      for (int c = 0; c < N_RC; c++)
        bus.len_rc[c*LEN_W +: LEN_W] = 8'($urandom_range(0, 10));
      grant_and_run("rand", 0, -1, cur_state, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
